// File: rtl/toggle_counter_pkg.sv
// Shared definitions for the toggle_counter block: direction encodings and
// the elaboration-time parameter legality check.
package toggle_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when WIDTH is 1..32 and MODULUS is 2..2**WIDTH.
    function automatic bit params_legal(input int width, input longint modulus);
        if (width < 1 || width > 32) begin
            return 1'b0;
        end
        if (modulus < 2) begin
            return 1'b0;
        end
        if (modulus > (longint'(1) << width)) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/toggle_counter_if.sv
// Control and status bundle for toggle_counter. The master drives the
// clear/load/count controls; the slave (the counter) returns the count,
// its complement, terminal count and the sticky wrap flag.
interface toggle_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             ovf;

    modport master (
        output clr, load, load_val, en, dir,
        input  q, q_bar, tc, ovf
    );

    modport slave (
        input  clr, load, load_val, en, dir,
        output q, q_bar, tc, ovf
    );
endinterface

// File: rtl/toggle_counter_tff_cell.sv
// One bit of the counter held in a T-type cell. The complement is kept in
// its own flop so q_bar is a true registered output, not an inverter.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    // Toggle both flops together; reset forces q=0, q_bar=1 immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= 1'b0;
            q_bar <= 1'b1;
        end else if (t) begin
            q     <= ~q;
            q_bar <= q;
        end
    end

endmodule

// File: rtl/toggle_counter.sv
// Modulo up/down counter built from T-type cells, with synchronous clear,
// clamped parallel load, combinational terminal count and a sticky wrap flag.
// Optional feature: define TOGGLE_COUNTER_SAT_EN to saturate at the ends of
// the range instead of wrapping (ovf then flags each blocked step).
module toggle_counter
    import toggle_counter_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256
) (
    input  logic             clk,
    input  logic             rst,
    toggle_counter_if.slave  bus
);

    if (!params_legal(WIDTH, MODULUS)) begin : g_param_check
        $fatal(1, "toggle_counter: WIDTH must be 1..32 and MODULUS 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] q_bar_int;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic             ovf_r;
    logic             next_ovf;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q_int == MAX_VAL);
    assign at_zero = (q_int == '0);

    // Next-count selection: clr beats load beats en, otherwise hold.
    always_comb begin
        next_q   = q_int;
        next_ovf = ovf_r;
        if (bus.clr) begin
            next_q   = '0;
            next_ovf = 1'b0;
        end else if (bus.load) begin
            next_q = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en) begin
            if (bus.dir == DIR_UP) begin
                if (at_max) begin
`ifdef TOGGLE_COUNTER_SAT_EN
                    next_q   = q_int;
`else
                    next_q   = '0;
`endif
                    next_ovf = 1'b1;
                end else begin
                    next_q = q_int + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef TOGGLE_COUNTER_SAT_EN
                    next_q   = q_int;
`else
                    next_q   = MAX_VAL;
`endif
                    next_ovf = 1'b1;
                end else begin
                    next_q = q_int - WIDTH'(1);
                end
            end
        end
    end

    assign t = q_int ^ next_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .t     (t[i]),
            .q     (q_int[i]),
            .q_bar (q_bar_int[i])
        );
    end

    // Sticky wrap flag; only clr or rst bring it back down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= next_ovf;
        end
    end

    assign bus.q     = q_int;
    assign bus.q_bar = q_bar_int;
    assign bus.ovf   = ovf_r;
    assign bus.tc    = bus.en & (((bus.dir == DIR_UP) & at_max) |
                                 ((bus.dir == DIR_DOWN) & at_zero));

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench for toggle_counter at WIDTH=4, MODULUS=10. Each
// stimulus step pushes the model's expected result into a scoreboard queue,
// which is popped and compared once the DUT has taken the clock edge.
module tb_toggle_counter;
    import toggle_counter_pkg::*;

    localparam int         WIDTH   = 4;
    localparam longint     MODULUS = 10;
    localparam logic [3:0] MAXV    = 4'd9;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [3:0] model_q;
    logic       model_ovf;

    toggle_counter_if #(.WIDTH(WIDTH)) bus ();

    toggle_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of controls, check tc before the edge, predict the
    // post-edge state and compare it once the edge has been taken.
    task automatic applyStimulus(input logic c, input logic l, input logic [3:0] lv,
                                 input logic e, input logic d, input string tag);
        exp_t       item;
        logic       exp_tc;
        logic [3:0] exp_qbar;
        bus.clr      = c;
        bus.load     = l;
        bus.load_val = lv;
        bus.en       = e;
        bus.dir      = d;
        #1;
        exp_tc = e && ((d == DIR_UP && model_q == MAXV) || (d == DIR_DOWN && model_q == 4'd0));
        checkOutput({tag, "_tc"}, bus.tc, exp_tc);
        if (c) begin
            model_q   = 4'd0;
            model_ovf = 1'b0;
        end else if (l) begin
            model_q = (lv > MAXV) ? MAXV : lv;
        end else if (e) begin
            if (d == DIR_UP) begin
                if (model_q == MAXV) begin
`ifndef TOGGLE_COUNTER_SAT_EN
                    model_q = 4'd0;
`endif
                    model_ovf = 1'b1;
                end else begin
                    model_q = model_q + 4'd1;
                end
            end else begin
                if (model_q == 4'd0) begin
`ifndef TOGGLE_COUNTER_SAT_EN
                    model_q = MAXV;
`endif
                    model_ovf = 1'b1;
                end else begin
                    model_q = model_q - 4'd1;
                end
            end
        end
        item.tag = tag;
        item.q   = model_q;
        item.ovf = model_ovf;
        sb.push_back(item);
        @(posedge clk);
        #1;
        item     = sb.pop_front();
        exp_qbar = ~item.q;
        checkOutput({item.tag, "_q"}, bus.q, item.q);
        checkOutput({item.tag, "_qbar"}, bus.q_bar, exp_qbar);
        checkOutput({item.tag, "_ovf"}, bus.ovf, item.ovf);
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by a randomized run.
    initial begin
        rst          = 1'b1;
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        bus.en       = 1'b0;
        bus.dir      = DIR_UP;
        model_q      = 4'd0;
        model_ovf    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_q", bus.q, 4'd0);
        checkOutput("reset_qbar", bus.q_bar, 4'hF);
        checkOutput("reset_ovf", bus.ovf, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, DIR_UP, "up_wrap");
        end

        applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, DIR_UP, "load6");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, DIR_UP, "hold6");
        end

        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, DIR_UP, "load0");
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, DIR_DOWN, "down_wrap");

        applyStimulus(1'b0, 1'b1, 4'hC, 1'b1, DIR_UP, "load_clamp");
        applyStimulus(1'b1, 1'b1, 4'h3, 1'b1, DIR_UP, "clr_load");

        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, DIR_DOWN, "down_wrap2");
        applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, DIR_UP, "load6b");
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, DIR_UP, "up_to7");

        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_q", bus.q, 4'd0);
        checkOutput("async_rst_qbar", bus.q_bar, 4'hF);
        checkOutput("async_rst_ovf", bus.ovf, 1'b0);
        #2;
        rst       = 1'b0;
        model_q   = 4'd0;
        model_ovf = 1'b0;

        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, DIR_UP, "post_rst");

        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                          4'($urandom_range(15)), ($urandom_range(3) != 0),
                          1'($urandom_range(1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; legal range 1..32.
REQ-002 Parameter MODULUS, default 256, count range 0..MODULUS-1; legal range 2..2**WIDTH; illegal values SHALL fail elaboration.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear to 0.
REQ-006 load  input  1  synchronous parallel load of load_val.
REQ-007 load_val  input  WIDTH  value to load.
REQ-008 en  input  1  count enable.
REQ-009 dir  input  1  count direction; 1 = up, 0 = down.
REQ-010 q  output  WIDTH  registered count.
REQ-011 q_bar  output  WIDTH  registered complement of q.
REQ-012 tc  output  1  combinational terminal count.
REQ-013 ovf  output  1  registered sticky wrap flag.

Function
REQ-014 Per-edge priority SHALL be clr > load > en; with none active, q SHALL hold.
REQ-015 clr SHALL set q=0 and ovf=0 on the next edge.
REQ-016 load SHALL set q=load_val on the next edge; load_val >= MODULUS SHALL load MODULUS-1. ovf is unchanged.
REQ-017 en with dir=1 SHALL set q=q+1; from q=MODULUS-1 it SHALL wrap to 0.
REQ-018 en with dir=0 SHALL set q=q-1; from q=0 it SHALL wrap to MODULUS-1.
REQ-019 Each wrap SHALL set ovf=1 on the same edge; ovf SHALL stay set until clr or rst.
REQ-020 tc SHALL equal en & ((dir & q==MODULUS-1) | (~dir & q==0)); it does not depend on clr or load.
REQ-021 q_bar SHALL equal ~q at all times after reset, including after load, clr and wrap.
REQ-022 Count update latency SHALL be one clock; dir and en SHALL be sampled on the same edge.
REQ-023 Each bit of q SHALL be held in a T-type cell with toggle input t[i] = q[i] ^ next_q[i].
REQ-024 When clr or load is asserted together with en on the same edge, counting SHALL NOT occur and ovf SHALL NOT set.

Reset
REQ-025 rst=1 SHALL immediately force q=0, q_bar=all ones and ovf=0, independent of clk.
REQ-026 If rst asserts mid-count, the count is abandoned. After rst deasserts, the first rising edge SHALL apply REQ-014 normally.

Configuration
REQ-027 Macro TOGGLE_COUNTER_SAT_EN, when defined, SHALL replace wrap with saturation:
- up at MODULUS-1 holds q;
- down at 0 holds q;
- ovf sets on any blocked step;
- tc is unchanged.
REQ-028 Without TOGGLE_COUNTER_SAT_EN, wrap behaviour per REQ-017..019 SHALL apply.

Structure
REQ-029 Package toggle_counter_pkg SHALL hold:
- direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
- the parameter-legality check function.
REQ-030 Sub-module tff_cell SHALL implement one bit:
- ports clk, rst, t, q, q_bar;
- asynchronous reset to q=0, q_bar=1;
- toggles when t=1.
toggle_counter SHALL instantiate WIDTH copies of tff_cell.

Verification (WIDTH=4, MODULUS=10)
REQ-031 Reset: rst=1 for 2 cycles -> q=0, q_bar=4'hF, ovf=0. rst pulsed asynchronously mid-count at q=7 -> q=0 before the next edge.
REQ-032 Up wrap: en=1, dir=1 for 10 cycles from 0 -> q steps 0..9, tc=1 while q=9, q=0 after edge 10, ovf=1. Under SAT_EN, q stays at 9 instead.
REQ-033 Down wrap: load_val=0 loaded, then en=1, dir=0 for 1 cycle -> q=9, ovf=1, and tc=1 is observed in the cycle before that edge.
REQ-034 Load clamp/priority: load=1, load_val=4'hC, en=1 -> q=9, no count. Then clr=1, load=1 together -> q=0, ovf=0.
REQ-035 Hold/complement: en=0 for 5 cycles at q=6 -> q=6, q_bar=4'h9 throughout. A randomized 200-cycle run -> q_bar==~q and q<10 on every cycle.
